mem_access_unit: RTL

//  Pipeline-side initiator for the word-wide data memory (Rd/Wr/Addr/wr_data/rd_data, 1-cycle registered read).

---
 rtl/mem_access_unit_if.sv | 49 ++++
 rtl/mem_access_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Bundles the request/response handshake of the MEM-stage load/store port
//   and the word-wide data-memory bus of mem_access_unit.
//   modport slave  : the access unit itself (takes requests, drives memory).
//   modport master : its environment, i.e. the pipeline stage issuing
//                    requests together with the memory returning rd_data.
// Signals
//   req_valid/req_ready           request handshake (accept on both high)
//   req_load/req_store            access kind (exactly one must be set)
//   req_size                      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned                  loads: 1 zero-extend, 0 sign-extend
//   req_addr/req_wdata            byte address, right-aligned store data
//   resp_valid/resp_err/resp_rdata  one-cycle completion with status/data
//   mem_rd/mem_wr/mem_addr/mem_wr_data/mem_rd_data  data-memory bus
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output req_valid, req_load, req_store, req_size, req_unsigned, req_addr,
           req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_rd, mem_wr,
           mem_addr, mem_wr_data
  );

  modport slave (
    input  req_valid, req_load, req_store, req_size, req_unsigned, req_addr,
           req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_rd, mem_wr,
           mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Pipeline-side initiator for a word-wide data memory with a 1-cycle
//   registered read. Takes one load/store at a time, turns the byte address
//   into a word index, sign/zero-extends byte/half/word loads (little-endian
//   lanes) and performs read-modify-write for byte/half stores. Misaligned or
//   malformed requests complete with resp_err and never touch memory.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    mem_access_unit_if.slave: request/response handshake plus the
//          memory bus (mem_rd, mem_wr, mem_addr, mem_wr_data, mem_rd_data)
// Build option
//   MAU_RANGE_CHECK_EN: when defined, a word index >= MEM_WORDS is also
//   rejected as an error. Undefined: the index is passed through unchecked.
module mem_access_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 11
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_MERGE, S_WR, S_DONE
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef MAU_RANGE_CHECK_EN
  localparam bit RangeCheck = 1'b1;
`else
  localparam bit RangeCheck = 1'b0;
`endif

  state_e            state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [DATA_W-1:0] mem_wr_data_q;
  logic [ADDR_W-1:0] mem_addr_q;

  // Request fields captured on accept, plus the old word for sub-word stores.
  logic              load_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [DATA_W-1:0] old_q;

  logic [ADDR_W-1:0] word_idx_d;
  logic              range_err_d;
  logic              err_d;

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic [1:0]        lane,
    input logic              uns
  );
    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;
    logic [7:0]        b;
    logic [15:0]       h;
    byte_sh = word >> {lane, 3'b000};
    half_sh = word >> {lane[1], 4'b0000};
    b = byte_sh[7:0];
    h = half_sh[15:0];
    case (size)
      SZ_BYTE: return {{(DATA_W-8){b[7] & ~uns}}, b};
      SZ_HALF: return {{(DATA_W-16){h[15] & ~uns}}, h};
      default: return word;
    endcase
  endfunction

  // Replace only the addressed byte/half lane of the old word.
  function automatic logic [DATA_W-1:0] store_merge(
    input logic [DATA_W-1:0] old,
    input logic [15:0]       wdata,
    input logic [1:0]        size,
    input logic [1:0]        lane
  );
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data;
    if (size == SZ_BYTE) begin
      mask = {{(DATA_W-8){1'b0}}, 8'hFF} << {lane, 3'b000};
      data = {{(DATA_W-8){1'b0}}, wdata[7:0]} << {lane, 3'b000};
    end else begin
      mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << {lane[1], 4'b0000};
      data = {{(DATA_W-16){1'b0}}, wdata} << {lane[1], 4'b0000};
    end
    return (old & ~mask) | data;
  endfunction

  assign word_idx_d  = {2'b00, bus.req_addr[ADDR_W-1:2]};
  assign range_err_d = RangeCheck && (word_idx_d >= ADDR_W'(MEM_WORDS));

  always_comb begin
    err_d = 1'b0;
    if (bus.req_load == bus.req_store) err_d = 1'b1;
    case (bus.req_size)
      SZ_BYTE: ;
      SZ_HALF: if (bus.req_addr[0])         err_d = 1'b1;
      SZ_WORD: if (bus.req_addr[1:0] != 0)  err_d = 1'b1;
      default: err_d = 1'b1;
    endcase
    if (range_err_d) err_d = 1'b1;
  end

  // Datapath capture: only consumed in states entered after an accept.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.req_valid) begin
      load_q  <= bus.req_load;
      uns_q   <= bus.req_unsigned;
      size_q  <= bus.req_size;
      lane_q  <= bus.req_addr[1:0];
      wdata_q <= bus.req_wdata[15:0];
    end
    if (state_q == S_WAIT) old_q <= bus.mem_rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      resp_rdata_q  <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      // Strobes are single-cycle; each state re-asserts what it needs.
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            mem_addr_q <= word_idx_d;
            if (err_d) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (bus.req_store && bus.req_size == SZ_WORD) begin
              state_q       <= S_WR;
              mem_wr_q      <= 1'b1;
              mem_wr_data_q <= bus.req_wdata;
            end else begin
              state_q  <= S_RD;
              mem_rd_q <= 1'b1;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_RD: state_q <= S_WAIT;
        S_WAIT: begin
          // mem_rd_data is valid this cycle (registered read issued in RD).
          if (load_q) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_extend(bus.mem_rd_data, size_q, lane_q, uns_q);
          end else begin
            state_q <= S_MERGE;
          end
        end
        S_MERGE: begin
          state_q       <= S_WR;
          mem_wr_q      <= 1'b1;
          mem_wr_data_q <= store_merge(old_q, wdata_q, size_q, lane_q);
        end
        S_WR: begin
          state_q      <= S_DONE;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;

endmodule
